multi_edge_sync: RTL and testbench
==================================

MULTI_EDGE_SYNC -- requirements
Module: multi_edge_sync

Interface
REQ-001 Parameter N_CH, default 4, number of independent asynchronous input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flip-flop depth per channel (2..4).
REQ-003 Parameter FILT, default 3, consecutive samples a new level must persist before acceptance (1..255).
REQ-004 Parameter CNT_W, default 8, width of each per-channel event counter (1..16).
REQ-005 clk  input  1  system clock; all state on posedge clk.
REQ-006 clr  input  1  reset, asynchronous, active-high.
REQ-007 async_in  input  N_CH  unsynchronized level inputs, one per channel.
REQ-008 mode  input  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 ack  input  N_CH  synchronous clear of pending[i] and ovf[i].
REQ-010 cnt_clr  input  N_CH  synchronous clear of the channel i event counter.
REQ-011 rd_sel  input  5  channel index for counter readback.
REQ-012 pulse_out  output  N_CH  one-cycle pulse per accepted event.
REQ-013 pending  output  N_CH  sticky event flag.
REQ-014 ovf  output  N_CH  sticky overrun flag: event arrived while pending set.
REQ-015 rd_cnt  output  CNT_W  event count of channel rd_sel.
REQ-016 ready  output  1  high once post-reset warm-up completes.

Function
REQ-017 Each channel SHALL pass async_in[i] through a SYNC_STAGES-deep flip-flop chain; only the last stage (s_last) is used downstream.
REQ-018 Filter: per channel, an 8-bit run counter SHALL count consecutive edges where s_last != level; level SHALL take s_last at the FILT-th consecutive differing edge, and the counter resets to 0 whenever s_last == level or level updates.
REQ-019 Latency: with the input transition captured by stage 0 at edge E1, level SHALL change at edge E(SYNC_STAGES+FILT) and pulse_out[i] SHALL be high for exactly the cycle following that edge.
REQ-020 Glitches shorter than FILT samples at s_last SHALL produce no level change and no pulse.
REQ-021 An event SHALL be accepted only when level changes in a direction enabled by mode[i] and ready=1; mode 00 suppresses events, but level tracking continues.
REQ-022 mode changes SHALL take effect at the next edge; no retroactive event for a level change already made.
REQ-023 On an accepted event: pulse_out[i] high one cycle; pending[i] set; counter increments, saturating at 2^CNT_W-1 (no wrap).
REQ-024 ovf[i] SHALL be set when an event is accepted while pending[i]=1 and ack[i]=0.
REQ-025 ack[i] with simultaneous event: pending[i] stays 1, ovf[i] clears to 0.
REQ-026 cnt_clr[i] with simultaneous event: counter becomes 1; cnt_clr[i] alone: counter becomes 0.
REQ-027 rd_cnt SHALL be combinational from rd_sel; rd_sel >= N_CH SHALL return 0.
REQ-028 Warm-up: after clr deasserts, a counter SHALL count SYNC_STAGES+FILT edges, then ready SHALL rise and stay high; level tracking runs during warm-up, so inputs static through reset produce no event.
REQ-029 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be recorded.

Reset
REQ-030 While clr=1: sync chains, level, run counters, event counters, pulse_out, pending, ovf = 0; ready = 0; warm-up counter = 0.
REQ-031 clr asserted mid-operation SHALL clear all state immediately, regardless of clk; a pulse in progress SHALL be truncated.

Verification
REQ-032 Defaults; ch0 mode 01; async_in[0] 0->1 held 10 cycles -> pulse_out[0] high exactly 1 cycle, sampled at edge 6 after capture; pending[0]=1; count=1.
REQ-033 mode 11, 2-cycle high glitch with FILT=3 -> no pulse, count unchanged; then 5-cycle high pulse -> two events (rise and fall), count=2.
REQ-034 Two rising events with no ack -> ovf=1; ack coincident with third event -> pending=1, ovf=0.
REQ-035 CNT_W=2, 5 events -> rd_cnt=3 (saturated); cnt_clr coincident with event -> rd_cnt=1; rd_sel=N_CH -> 0.
REQ-036 async_in all 1 during clr, release -> ready rises after 5 edges, no pulse_out on any channel; clr mid-filter-count -> all outputs 0 at once.

Source files
------------

// File: rtl/multi_edge_sync.sv
// multi_edge_sync
//   Per-channel synchronizer, glitch filter and edge-event recorder for
//   N_CH unrelated asynchronous level inputs.
//
//   Each channel:
//     async_in -> SYNC_STAGES flop chain -> run-length filter (FILT samples)
//     -> filtered level -> edge qualified by mode and ready -> event.
//   Each event produces a one-cycle pulse, sets a sticky pending flag,
//   sets an overrun flag if pending was already set, and bumps a
//   saturating counter.
//
// Ports
//   clk        system clock, all state on posedge
//   clr        asynchronous active-high reset
//   async_in   [N_CH]    unsynchronized level inputs
//   mode       [2*N_CH]  per channel: 00 off, 01 rise, 10 fall, 11 both
//   ack        [N_CH]    clears pending/ovf (pending re-set by a coincident event)
//   cnt_clr    [N_CH]    clears event counter (to 1 with a coincident event)
//   rd_sel     [5]       channel index for rd_cnt
//   pulse_out  [N_CH]    one-cycle pulse per accepted event
//   pending    [N_CH]    sticky event flag
//   ovf        [N_CH]    sticky overrun flag
//   rd_cnt     [CNT_W]   counter of channel rd_sel, 0 when rd_sel >= N_CH
//   ready      warm-up complete

module multi_edge_sync #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [N_CH-1:0]     async_in,
  input  logic [2*N_CH-1:0]   mode,
  input  logic [N_CH-1:0]     ack,
  input  logic [N_CH-1:0]     cnt_clr,
  input  logic [4:0]          rd_sel,
  output logic [N_CH-1:0]     pulse_out,
  output logic [N_CH-1:0]     pending,
  output logic [N_CH-1:0]     ovf,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic                ready
);

  localparam int unsigned WARM = SYNC_STAGES + FILT;

  logic [SYNC_STAGES-1:0] sync [N_CH];
  logic [7:0]             run  [N_CH];
  logic [CNT_W-1:0]       cnt  [N_CH];
  logic [N_CH-1:0]        level;
  logic [N_CH-1:0]        s_last;
  logic [N_CH-1:0]        chg;
  logic [N_CH-1:0]        evt;
  logic [8:0]             wcnt;

  // Level change happens on the FILT-th consecutive differing sample, so the
  // change is detected while run still holds FILT-1. The event is qualified
  // by the direction of the new level and the current mode.
  always_comb begin
    s_last = '0;
    chg    = '0;
    evt    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      s_last[i] = sync[i][SYNC_STAGES-1];
      chg[i]    = (s_last[i] != level[i]) && (run[i] == 8'(FILT - 1));
      unique case (mode[2*i +: 2])
        2'b01:   evt[i] = chg[i] && ready && s_last[i];
        2'b10:   evt[i] = chg[i] && ready && !s_last[i];
        2'b11:   evt[i] = chg[i] && ready;
        default: evt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        sync[i] <= '0;
        run[i]  <= '0;
        cnt[i]  <= '0;
      end
      level     <= '0;
      pulse_out <= '0;
      pending   <= '0;
      ovf       <= '0;
      wcnt      <= '0;
      ready     <= 1'b0;
    end else begin
      // Warm-up: ready rises on the WARM-th edge after reset release.
      if (!ready) begin
        if (wcnt == 9'(WARM - 1)) ready <= 1'b1;
        else                      wcnt  <= wcnt + 9'd1;
      end

      pulse_out <= evt;

      for (int unsigned i = 0; i < N_CH; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], async_in[i]};

        if ((s_last[i] == level[i]) || chg[i]) run[i] <= '0;
        else                                   run[i] <= run[i] + 8'd1;
        if (chg[i]) level[i] <= s_last[i];

        // ack wins over overrun detection; a coincident event keeps pending set.
        if (ack[i]) begin
          pending[i] <= evt[i];
          ovf[i]     <= 1'b0;
        end else if (evt[i]) begin
          pending[i] <= 1'b1;
          if (pending[i]) ovf[i] <= 1'b1;
        end

        if (cnt_clr[i])                     cnt[i] <= evt[i] ? CNT_W'(1) : '0;
        else if (evt[i] && (cnt[i] != '1))  cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_sel == 5'(i)) rd_cnt = cnt[i];
    end
  end

endmodule

// File: tb/tb_multi_edge_sync.sv
// Bench for multi_edge_sync: default-parameter instance checked through a
// pulse scoreboard plus direct flag/counter checks; a CNT_W=2 instance checks
// counter saturation and cnt_clr behaviour.

module tb_multi_edge_sync;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] async_in, ack, cnt_clr, pulse_out, pending, ovf;
  logic [7:0] mode;
  logic [4:0] rd_sel;
  logic [7:0] rd_cnt;
  logic       ready;

  logic [3:0] b_async_in, b_ack, b_cnt_clr, b_pulse_out, b_pending, b_ovf;
  logic [7:0] b_mode;
  logic [4:0] b_rd_sel;
  logic [1:0] b_rd_cnt;
  logic       b_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int ch;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  multi_edge_sync dut (
    .clk(clk), .clr(clr), .async_in(async_in), .mode(mode), .ack(ack),
    .cnt_clr(cnt_clr), .rd_sel(rd_sel), .pulse_out(pulse_out),
    .pending(pending), .ovf(ovf), .rd_cnt(rd_cnt), .ready(ready)
  );

  multi_edge_sync #(.N_CH(4), .SYNC_STAGES(2), .FILT(3), .CNT_W(2)) dut_b (
    .clk(clk), .clr(clr), .async_in(b_async_in), .mode(b_mode), .ack(b_ack),
    .cnt_clr(b_cnt_clr), .rd_sel(b_rd_sel), .pulse_out(b_pulse_out),
    .pending(b_pending), .ovf(b_ovf), .rd_cnt(b_rd_cnt), .ready(b_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input changed now is captured at the next edge (E1); with 2 sync stages
  // and FILT=3 the level changes at E5, so the pulse is seen after edge cyc+5.
  task automatic expect_pulse(input int ch);
    exp_t e;
    e.cyc = cyc + 5;
    e.ch  = ch;
    sbq.push_back(e);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  // Pulse monitor: every pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (pulse_out[c]) begin
        if (sbq.size() == 0) begin
          chk("pulse_unexpected_ch", c, 99);
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_ch", c, mon_e.ch);
          chk("pulse_cyc", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    clr = 1'b1;
    async_in = 4'hF; mode = '0; ack = '0; cnt_clr = '0; rd_sel = '0;
    b_async_in = '0; b_mode = '0; b_ack = '0; b_cnt_clr = '0; b_rd_sel = '0;
    tick(3);
    chk("rst_pulse", pulse_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", ready, 0);
    chk("rst_rd_cnt", rd_cnt, 0);

    // Inputs high through reset, all modes enabled: no event may appear.
    mode = 8'hFF;
    clr = 1'b0;
    tick(4);
    chk("warm_ready_e4", ready, 0);
    tick(1);
    chk("warm_ready_e5", ready, 1);
    tick(10);
    chk("warm_pending", pending, 0);

    // Bring all inputs low with modes off: levels follow, no events.
    mode = '0;
    async_in = '0;
    tick(10);

    // Single rising edge on ch0.
    set_mode(0, 2'b01);
    async_in[0] = 1'b1; expect_pulse(0);
    tick(10);
    chk("ch0_pending", pending[0], 1);
    rd_sel = 5'd0;
    #1 chk("ch0_cnt", rd_cnt, 1);
    ack[0] = 1'b1; tick(1); ack[0] = 1'b0;
    chk("ch0_ack_pending", pending[0], 0);
    async_in[0] = 1'b0;            // falling edge, rising-only mode: no event
    tick(10);

    // ch1 both edges: a 2-cycle glitch is filtered, a 5-cycle pulse is not.
    set_mode(1, 2'b11);
    async_in[1] = 1'b1; tick(2); async_in[1] = 1'b0;
    tick(10);
    rd_sel = 5'd1;
    #1 chk("ch1_glitch_cnt", rd_cnt, 0);
    async_in[1] = 1'b1; expect_pulse(1);
    tick(5);
    async_in[1] = 1'b0; expect_pulse(1);
    tick(10);
    chk("ch1_cnt", rd_cnt, 2);

    // ch2 overrun, then ack coincident with the third event.
    set_mode(2, 2'b01);
    async_in[2] = 1'b1; expect_pulse(2); tick(8);
    async_in[2] = 1'b0; tick(8);
    async_in[2] = 1'b1; expect_pulse(2); tick(8);
    chk("ch2_ovf_pending", pending[2], 1);
    chk("ch2_ovf", ovf[2], 1);
    async_in[2] = 1'b0; tick(8);
    async_in[2] = 1'b1; expect_pulse(2);
    tick(4);
    ack[2] = 1'b1; tick(1); ack[2] = 1'b0;
    chk("ch2_ack_evt_pending", pending[2], 1);
    chk("ch2_ack_evt_ovf", ovf[2], 0);
    rd_sel = 5'd2;
    #1 chk("ch2_cnt", rd_cnt, 3);

    // Simultaneous edges on every channel (ch2 already high: no change there).
    ack = 4'hF; tick(1); ack = '0;
    mode = 8'hFF;
    async_in = 4'hF;
    expect_pulse(0); expect_pulse(1); expect_pulse(3);
    tick(10);
    chk("all_pending", pending, 4'b1011);
    rd_sel = 5'd3;
    #1 chk("ch3_cnt", rd_cnt, 1);
    rd_sel = 5'd4;
    #1 chk("rd_sel_oob", rd_cnt, 0);

    // Mode off on ch3: level follows but nothing is recorded.
    set_mode(3, 2'b00);
    async_in[3] = 1'b0;
    tick(10);
    rd_sel = 5'd3;
    #1 chk("ch3_off_cnt", rd_cnt, 1);

    // cnt_clr alone.
    cnt_clr[0] = 1'b1; tick(1); cnt_clr[0] = 1'b0;
    rd_sel = 5'd0;
    #1 chk("ch0_cnt_clr", rd_cnt, 0);

    // Narrow instance: saturation and cnt_clr coincident with an event.
    b_mode = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      b_async_in[0] = ~b_async_in[0];
      tick(8);
    end
    #1 chk("b_sat_cnt", b_rd_cnt, 3);
    b_async_in[0] = ~b_async_in[0];
    tick(4);
    b_cnt_clr[0] = 1'b1; tick(1); b_cnt_clr[0] = 1'b0;
    #1 chk("b_clr_evt_cnt", b_rd_cnt, 1);
    b_rd_sel = 5'd4;
    #1 chk("b_rd_sel_oob", b_rd_cnt, 0);

    // Reset in the middle of a filter run clears everything immediately.
    async_in[0] = 1'b0;
    tick(3);
    #2 clr = 1'b1;
    #1;
    chk("midclr_pulse", pulse_out, 0);
    chk("midclr_pending", pending, 0);
    chk("midclr_ovf", ovf, 0);
    chk("midclr_ready", ready, 0);
    chk("midclr_rd_cnt", rd_cnt, 0);
    chk("midclr_b_rd_cnt", b_rd_cnt, 0);
    tick(4);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
